// File: rtl/bus_ctrl_pkg.sv
// Shared types and defaults for the 68000 bus acknowledge logic.
// Region codes, FSM states and default wait-state constants.
package bus_ctrl_pkg;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_ROM,
      REG_RAM,
      REG_IO,
      REG_CAN,
      REG_DRAM,
      REG_GFX
   } region_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK,
      ERR
   } state_t;

   localparam int unsigned DEF_ROM_WAIT = 1;
   localparam int unsigned DEF_RAM_WAIT = 1;
   localparam int unsigned DEF_IO_WAIT  = 3;
   localparam int unsigned DEF_CAN_WAIT = 7;
   localparam int unsigned DEF_TIMEOUT  = 255;
   localparam int unsigned DEF_CNT_W    = 8;

   // Regions acknowledged by a local wait counter rather than an external ack.
   function automatic logic is_fixed(region_t r);
      return (r == REG_ROM) || (r == REG_RAM) ||
             (r == REG_IO)  || (r == REG_CAN);
   endfunction

endpackage

// File: rtl/bus_region_encoder.sv
// Priority encoder from address decoder selects to a region code.
// ROM > RAM > IO > CAN > DRAM > GRAPHICS > NONE.
module bus_region_encoder
   import bus_ctrl_pkg::*;
(
   input  logic    rom_sel_i,
   input  logic    ram_sel_i,
   input  logic    io_sel_i,
   input  logic    can_sel_i,
   input  logic    dram_sel_i,
   input  logic    gfx_cs_l_i,
   output region_t region_o
);

   // Highest-priority active select wins.
   always_comb begin
      region_o = REG_NONE;
      if (rom_sel_i)
         region_o = REG_ROM;
      else if (ram_sel_i)
         region_o = REG_RAM;
      else if (io_sel_i)
         region_o = REG_IO;
      else if (can_sel_i)
         region_o = REG_CAN;
      else if (dram_sel_i)
         region_o = REG_DRAM;
      else if (!gfx_cs_l_i)
         region_o = REG_GFX;
   end

endmodule

// File: rtl/bus_dtack_controller.sv
// DTACK/BERR generator for one 68000 bus: fixed wait-states for
// on-chip regions, pass-through ack for DRAM/graphics, timeout BERR.
module bus_dtack_controller
   import bus_ctrl_pkg::*;
#(
   parameter int unsigned ROM_WAIT = DEF_ROM_WAIT,
   parameter int unsigned RAM_WAIT = DEF_RAM_WAIT,
   parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
   parameter int unsigned CAN_WAIT = DEF_CAN_WAIT,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic Clk,
   input  logic Reset_L,
   input  logic AS_L,
   input  logic UDS_L,
   input  logic LDS_L,
   input  logic OnChipRomSelect_H,
   input  logic OnChipRamSelect_H,
   input  logic IOSelect_H,
   input  logic CanBusSelect_H,
   input  logic DramSelect_H,
   input  logic GraphicsCS_L,
   input  logic DramDtack_L,
   input  logic GraphicsDtack_L,
   output logic DTACK_L,
   output logic BERR_L,
   output logic BusBusy_H
);

   region_t            region_w;
   region_t            region_q;
   state_t             state_q;
   logic [CNT_W-1:0]   wcnt_q;
   logic [CNT_W-1:0]   wcnt_d;
   logic [CNT_W-1:0]   wload_d;
   logic [CNT_W-1:0]   tcnt_q;
   logic [CNT_W-1:0]   tcnt_d;
   logic               dtack_q;
   logic               berr_q;
   logic               busy_q;
   logic               start_w;
   logic               ack_hit_w;
   logic               timeout_w;

   bus_region_encoder u_enc (
      .rom_sel_i  (OnChipRomSelect_H),
      .ram_sel_i  (OnChipRamSelect_H),
      .io_sel_i   (IOSelect_H),
      .can_sel_i  (CanBusSelect_H),
      .dram_sel_i (DramSelect_H),
      .gfx_cs_l_i (GraphicsCS_L),
      .region_o   (region_w)
   );

   // Cycle-start detect and the wait value for the region being entered.
   always_comb begin
      start_w = !AS_L && (!UDS_L || !LDS_L);
      wload_d = '0;
      case (region_w)
         REG_ROM: wload_d = CNT_W'(ROM_WAIT);
         REG_RAM: wload_d = CNT_W'(RAM_WAIT);
         REG_IO:  wload_d = CNT_W'(IO_WAIT);
         REG_CAN: wload_d = CNT_W'(CAN_WAIT);
         default: wload_d = '0;
      endcase
   end

   // Ack source for the latched region, plus counter next values.
   always_comb begin
      ack_hit_w = 1'b0;
      if (is_fixed(region_q))
         ack_hit_w = (wcnt_q == '0);
      else if (region_q == REG_DRAM)
         ack_hit_w = !DramDtack_L;
      else if (region_q == REG_GFX)
         ack_hit_w = !GraphicsDtack_L;
      wcnt_d    = (wcnt_q != '0) ? wcnt_q - 1'b1 : wcnt_q;
      tcnt_d    = tcnt_q + 1'b1;
      timeout_w = (tcnt_d == CNT_W'(TIMEOUT));
   end

   // Bus cycle FSM with registered DTACK/BERR/busy outputs.
   always_ff @(posedge Clk) begin
      if (!Reset_L) begin
         state_q  <= IDLE;
         region_q <= REG_NONE;
         wcnt_q   <= '0;
         tcnt_q   <= '0;
         dtack_q  <= 1'b1;
         berr_q   <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               dtack_q <= 1'b1;
               berr_q  <= 1'b1;
               if (start_w) begin
                  state_q  <= WAIT;
                  region_q <= region_w;
                  wcnt_q   <= wload_d;
                  tcnt_q   <= '0;
                  busy_q   <= 1'b1;
               end
            end
            WAIT: begin
               // A released strobe aborts silently; ack beats timeout.
               if (AS_L) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (ack_hit_w) begin
                  state_q <= ACK;
                  dtack_q <= 1'b0;
               end else if (timeout_w) begin
                  state_q <= ERR;
                  berr_q  <= 1'b0;
               end else begin
                  tcnt_q <= tcnt_d;
                  wcnt_q <= wcnt_d;
               end
            end
            ACK, ERR: begin
               if (AS_L) begin
                  state_q <= IDLE;
                  dtack_q <= 1'b1;
                  berr_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign DTACK_L   = dtack_q;
   assign BERR_L    = berr_q;
   assign BusBusy_H = busy_q;

endmodule

// File: tb/tb_bus_dtack_controller.sv
// Self-checking bench for bus_dtack_controller.
// Directed scenarios plus randomized cycles against an edge-level model.
module tb_bus_dtack_controller;

   localparam int TO = 255;

   typedef struct packed {
      int dt;
      int be;
      int cnt;
      int idle;
      bit busy0;
      bit bad;
   } obs_t;

   logic Clk = 1'b0;
   logic Reset_L = 1'b0;
   logic AS_L = 1'b1;
   logic UDS_L = 1'b1;
   logic LDS_L = 1'b1;
   logic RomSel = 1'b0;
   logic RamSel = 1'b0;
   logic IoSel = 1'b0;
   logic CanSel = 1'b0;
   logic DramSel = 1'b0;
   logic GfxCs_L = 1'b1;
   logic DramDtack_L = 1'b1;
   logic GfxDtack_L = 1'b1;
   logic DTACK_L;
   logic BERR_L;
   logic BusBusy_H;

   int checks = 0;
   int errors = 0;

   bus_dtack_controller dut (
      .Clk               (Clk),
      .Reset_L           (Reset_L),
      .AS_L              (AS_L),
      .UDS_L             (UDS_L),
      .LDS_L             (LDS_L),
      .OnChipRomSelect_H (RomSel),
      .OnChipRamSelect_H (RamSel),
      .IOSelect_H        (IoSel),
      .CanBusSelect_H    (CanSel),
      .DramSelect_H      (DramSel),
      .GraphicsCS_L      (GfxCs_L),
      .DramDtack_L       (DramDtack_L),
      .GraphicsDtack_L   (GfxDtack_L),
      .DTACK_L           (DTACK_L),
      .BERR_L            (BERR_L),
      .BusBusy_H         (BusBusy_H)
   );

   always #5 Clk = ~Clk;

   // sel = {rom, ram, io, can, dram, gfx}; region 0=none .. 6=gfx
   function automatic int region_of(logic [5:0] s);
      if (s[5]) return 1;
      if (s[4]) return 2;
      if (s[3]) return 3;
      if (s[2]) return 4;
      if (s[1]) return 5;
      if (s[0]) return 6;
      return 0;
   endfunction

   // Expected observations, edges counted from the start edge 0.
   function automatic obs_t model(logic [5:0] s, bit uds, bit lds,
                                  int ext, int rel, int rst);
      obs_t o;
      int r, a, term, fin;
      bit isack;
      o = '{dt: -1, be: -1, cnt: 0, idle: 1, busy0: 1'b0, bad: 1'b0};
      if ((uds && lds) || rst == 0) return o;
      r = region_of(s);
      case (r)
         1, 2:    a = 2;
         3:       a = 4;
         4:       a = 8;
         5, 6:    a = (ext < 0) ? -1 : ((ext < 1) ? 1 : ext);
         default: a = -1;
      endcase
      if (a > TO) a = -1;
      isack = (a >= 0);
      term  = isack ? a : TO;
      fin   = (rst >= 0 && rst < rel) ? rst : rel;
      o.busy0 = 1'b1;
      o.idle  = fin;
      if (fin > term) begin
         o.cnt = fin - term;
         if (isack) o.dt = term;
         else       o.be = term;
      end
      return o;
   endfunction

   task automatic run_cycle(input logic [5:0] s, input bit uds, input bit lds,
                            input int ext, input int rel, input int rst,
                            output obs_t o);
      int last;
      logic [5:0] rs;
      o = '{dt: -1, be: -1, cnt: 0, idle: -1, busy0: 1'b0, bad: 1'b0};
      last = (rst >= 0 && rst < rel) ? rst : rel;
      for (int k = 0; k <= last; k++) begin
         rs = (k == 0) ? s : 6'($urandom);
         {RomSel, RamSel, IoSel, CanSel, DramSel} = rs[5:1];
         GfxCs_L     = !rs[0];
         AS_L        = (k >= rel);
         UDS_L       = (k >= rel) ? 1'b1 : uds;
         LDS_L       = (k >= rel) ? 1'b1 : lds;
         DramDtack_L = !(ext >= 0 && k >= ext);
         GfxDtack_L  = !(ext >= 0 && k >= ext);
         Reset_L     = !(k == rst);
         @(posedge Clk);
         #1;
         if (!DTACK_L) begin
            if (o.dt < 0) o.dt = k;
            o.cnt++;
         end
         if (!BERR_L) begin
            if (o.be < 0) o.be = k;
            o.cnt++;
         end
         if (!DTACK_L && !BERR_L) o.bad = 1'b1;
         if (k == 0) o.busy0 = BusBusy_H;
         else if (!BusBusy_H && o.idle < 0) o.idle = k;
      end
      Reset_L = 1'b1;
      AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
      {RomSel, RamSel, IoSel, CanSel, DramSel} = '0;
      GfxCs_L = 1'b1; DramDtack_L = 1'b1; GfxDtack_L = 1'b1;
   endtask

   task automatic test_reset();
      Reset_L = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if (DTACK_L !== 1'b1) begin
         errors++;
         $display("FAIL reset_dtack: got %b expected 1", DTACK_L);
      end
      checks++;
      if (BERR_L !== 1'b1) begin
         errors++;
         $display("FAIL reset_berr: got %b expected 1", BERR_L);
      end
      checks++;
      if (BusBusy_H !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b expected 0", BusBusy_H);
      end
      Reset_L = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_cycle(input string nm, input logic [5:0] s,
                             input bit uds, input bit lds,
                             input int ext, input int rel, input int rst);
      obs_t got, exp;
      exp = model(s, uds, lds, ext, rel, rst);
      run_cycle(s, uds, lds, ext, rel, rst, got);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got dt=%0d be=%0d cnt=%0d idle=%0d busy0=%0d bad=%0d expected dt=%0d be=%0d cnt=%0d idle=%0d busy0=%0d bad=%0d",
                  nm, got.dt, got.be, got.cnt, got.idle, got.busy0, got.bad,
                  exp.dt, exp.be, exp.cnt, exp.idle, exp.busy0, exp.bad);
      end
   endtask

   task automatic test_rom();
      test_cycle("rom_read", 6'b100000, 1'b0, 1'b0, -1, 5, -1);
   endtask

   task automatic test_io_lds();
      test_cycle("io_lds", 6'b001000, 1'b1, 1'b0, 2, 7, -1);
   endtask

   task automatic test_dram();
      test_cycle("dram_ack6", 6'b000010, 1'b0, 1'b0, 6, 9, -1);
      test_cycle("dram_tie", 6'b000010, 1'b0, 1'b0, 255, 258, -1);
      test_cycle("gfx_ack", 6'b000001, 1'b0, 1'b1, 3, 6, -1);
   endtask

   task automatic test_unmapped();
      test_cycle("unmapped", 6'b000000, 1'b0, 1'b0, 10, 257, -1);
   endtask

   task automatic test_priority();
      test_cycle("rom_over_io", 6'b101000, 1'b0, 1'b0, -1, 4, -1);
      test_cycle("ram_over_dram", 6'b010010, 1'b0, 1'b0, 30, 4, -1);
   endtask

   task automatic test_abort();
      test_cycle("can_abort", 6'b000100, 1'b0, 1'b0, -1, 3, -1);
   endtask

   task automatic test_no_strobe();
      test_cycle("no_strobe", 6'b100000, 1'b1, 1'b1, -1, 5, -1);
   endtask

   task automatic test_reset_mid();
      test_cycle("can_reset", 6'b000100, 1'b0, 1'b0, -1, 12, 4);
      test_cycle("rom_after_rst", 6'b100000, 1'b0, 1'b0, -1, 4, -1);
   endtask

   task automatic test_back_to_back();
      test_cycle("b2b_can", 6'b000100, 1'b0, 1'b0, -1, 10, -1);
      test_cycle("b2b_ram", 6'b010000, 1'b1, 1'b0, -1, 3, -1);
      test_cycle("b2b_io", 6'b001000, 1'b0, 1'b1, -1, 6, -1);
   endtask

   task automatic test_random();
      logic [5:0] s;
      bit uds, lds;
      int ext, rel, rst;
      for (int i = 0; i < 30; i++) begin
         s = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
         if ($urandom_range(0, 3) == 0)
            s = 6'($urandom_range(1, 3));
         uds = 1'($urandom);
         lds = 1'($urandom);
         if ($urandom_range(0, 7) != 0 && uds && lds) lds = 1'b0;
         ext = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20));
         rel = ($urandom_range(0, 6) == 0) ? int'($urandom_range(250, 262))
                                           : int'($urandom_range(1, 24));
         rst = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, rel)) : -1;
         test_cycle($sformatf("rand%0d", i), s, uds, lds, ext, rel, rst);
      end
   endtask

   initial begin
      test_reset();
      test_rom();
      test_io_lds();
      test_dram();
      test_unmapped();
      test_priority();
      test_abort();
      test_no_strobe();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_dtack_controller.md
Name: bus_dtack_controller

Overview:
- Sits directly downstream of the address decoder.
- Consumes the per-region select lines and the 68000 strobes, then generates DTACK_L to the CPU: fixed wait-states for on-chip ROM, on-chip RAM, IO and CAN; pass-through acknowledge for DRAM and graphics.
- Raises BERR_L when a cycle is unmapped or never acknowledged.
- One instance per CPU bus; single clock domain.

Parameters:
ROM_WAIT, 1, extra clocks before DTACK_L for on-chip ROM
RAM_WAIT, 1, extra clocks for on-chip RAM
IO_WAIT, 3, extra clocks for IO space
CAN_WAIT, 7, extra clocks for CAN controller
TIMEOUT, 255, clocks from cycle start to BERR_L if no DTACK (must exceed every WAIT)
CNT_W, 8, counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset_L  in  1  synchronous active-low reset
AS_L  in  1  CPU address strobe
UDS_L  in  1  upper data strobe
LDS_L  in  1  lower data strobe
OnChipRomSelect_H  in  1  from address decoder
OnChipRamSelect_H  in  1  from address decoder
IOSelect_H  in  1  from address decoder
CanBusSelect_H  in  1  from address decoder
DramSelect_H  in  1  from address decoder
GraphicsCS_L  in  1  from address decoder, active low
DramDtack_L  in  1  acknowledge from DRAM controller
GraphicsDtack_L  in  1  acknowledge from graphics block
DTACK_L  out  1  registered data acknowledge to CPU
BERR_L  out  1  registered bus error to CPU
BusBusy_H  out  1  high while state != IDLE

Behaviour:
- Clock and reset: one clock, Clk. Reset_L is synchronous, active low. Reset has priority over every other event.
- Reset values: DTACK_L=1, BERR_L=1, BusBusy_H=0, state=IDLE, counters=0.
- Reset asserted mid-cycle: outputs return to reset values at that edge. No ack is issued for the aborted cycle.
- Cycle start: in IDLE, AS_L=0 and (UDS_L=0 or LDS_L=0) sampled at edge N.
  - Go to WAIT.
  - Latch the region code.
  - Load wait counter with the region's WAIT value; clear timeout counter.
  - AS_L=0 with both data strobes high does not start a cycle; stay in IDLE.
- Region priority when several selects are active: ROM > RAM > IO > CAN > DRAM > GRAPHICS > NONE.
- Selects are sampled only at cycle start and ignored afterwards.
- Fixed-wait regions (ROM/RAM/IO/CAN), in WAIT:
  - Counter==0: DTACK_L<=0, go to ACK.
  - Otherwise decrement.
  - WAIT=0 gives DTACK_L low after edge N+1; WAIT=k gives edge N+1+k.
- External regions (DRAM/GRAPHICS), in WAIT: when the respective *Dtack_L is sampled 0, DTACK_L<=0 at that edge and go to ACK.
- Timeout:
  - The timeout counter increments every cycle in WAIT.
  - On reaching TIMEOUT, BERR_L<=0 and go to ERR (edge N+TIMEOUT).
  - Region NONE always ends this way.
  - If ack and timeout coincide on the same edge, the ack wins.
- ACK/ERR:
  - Hold DTACK_L (or BERR_L) low while AS_L=0.
  - At the first edge sampling AS_L=1, drive both outputs high and go to IDLE.
  - The next cycle may start at the following edge. There are no back-to-back cycles without AS_L going high.
- Aborted cycle: AS_L sampled 1 during WAIT returns to IDLE with no DTACK_L/BERR_L pulse.
- DTACK_L and BERR_L are never low simultaneously.
- BusBusy_H is registered, high in WAIT/ACK/ERR.

Decomposition:
- Shared package bus_ctrl_pkg:
  - Region enum: REG_NONE, REG_ROM, REG_RAM, REG_IO, REG_CAN, REG_DRAM, REG_GFX.
  - FSM state enum: IDLE, WAIT, ACK, ERR.
  - Default wait constants.
- Sub-module bus_region_encoder: purely combinational priority encoder from the select lines to the region code. Instantiated once.
- Counters and FSM stay in the top module.

Test Plan:
1. ROM read at defaults: AS_L/UDS_L/LDS_L low with ROM select at edge 0 -> DTACK_L low at edge 2, held until AS_L high, then DTACK_L high at the sampling edge.
2. IO write, LDS_L only: IOSelect_H=1 -> DTACK_L low at edge 4; BERR_L stays 1 throughout.
3. DRAM cycle: DramDtack_L low at edge 6 -> DTACK_L low at edge 6. Separate run with DramDtack_L low on the same edge as timeout 255 -> DTACK_L, not BERR_L.
4. Unmapped address (all selects inactive, GraphicsCS_L=1) -> BERR_L low at edge 255, DTACK_L stays 1, both high one edge after AS_L returns high.
5. ROM and IO selects both high -> ROM timing (edge 2). AS_L released at edge 2 of a CAN cycle -> no DTACK_L pulse, BusBusy_H low at edge 3.
6. Reset_L low during WAIT of a CAN cycle -> all outputs at reset values at that edge. A fresh ROM cycle after reset acks at edge 2.
